fht_bank_wr: RTL and testbench

Write-back controller for the FHT datapath, at the output end of the butterfly block.
- Accepts one beat per cycle: four already-mixed butterfly results, one per memory bank.
- Buffers them in a small FIFO and issues the bank write port (common address, per-bank data) whenever the memory arbiter grants a write slot.
- Counts beats per stage and reports stage/transform completion to the sequencer.

---
 rtl/fht_pkg.sv | 15 +
 rtl/fht_bank_wr_if.sv | 35 +++
 rtl/fht_wr_fifo.sv | 62 ++++++
 rtl/fht_bank_wr.sv | 138 +++++++++++++
 tb/tb_fht_bank_wr.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT write-back path: default widths and FSM encodings.
package fht_pkg;

  localparam int unsigned D_BIT_DEF      = 17;
  localparam int unsigned A_BIT_DEF      = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/fht_bank_wr_if.sv
// Beat input and bank write port of the FHT write-back controller.
interface fht_bank_wr_if
  import fht_pkg::*;
#(
  parameter int unsigned D_BIT = D_BIT_DEF,
  parameter int unsigned A_BIT = A_BIT_DEF
) ();

  logic                    iVALID;
  logic signed [D_BIT-1:0] iY_0;
  logic signed [D_BIT-1:0] iY_1;
  logic signed [D_BIT-1:0] iY_2;
  logic signed [D_BIT-1:0] iY_3;
  logic                    iWR_GRANT;

  logic                    oWE;
  logic [A_BIT-1:0]        oADDR;
  logic signed [D_BIT-1:0] oD_0;
  logic signed [D_BIT-1:0] oD_1;
  logic signed [D_BIT-1:0] oD_2;
  logic signed [D_BIT-1:0] oD_3;

  // Producer side: butterfly results in, arbiter grant in, bank writes observed.
  modport master (
    output iVALID, iY_0, iY_1, iY_2, iY_3, iWR_GRANT,
    input  oWE, oADDR, oD_0, oD_1, oD_2, oD_3
  );

  // Controller side.
  modport slave (
    input  iVALID, iY_0, iY_1, iY_2, iY_3, iWR_GRANT,
    output oWE, oADDR, oD_0, oD_1, oD_2, oD_3
  );

endinterface

// File: rtl/fht_wr_fifo.sv
// Holding FIFO for tagged write beats; push and pop may coincide at any occupancy.
module fht_wr_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic [PW:0]      cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rdata_c_o = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q   <= cnt_d;
      full_o  <= (cnt_d == (PW+1)'(DEPTH));
      empty_o <= (cnt_d == '0);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge iCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fht_bank_wr.sv
// FHT bank write-back controller: buffers four-bank beats, writes them on grant,
// and reports stage/transform completion.
// Optional macro FHT_WR_SCALE_EN: write each word as (y + 1) >>> 1 (halving with
// round-half-up); the FIFO always holds unscaled data.
module fht_bank_wr
  import fht_pkg::*;
#(
  parameter int unsigned D_BIT      = D_BIT_DEF,
  parameter int unsigned A_BIT      = A_BIT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iSTART,
  input  logic          iLAST_STAGE,
  fht_bank_wr_if.slave  bus,
  output logic          oBUSY,
  output logic          oSTAGE_DONE,
  output logic          oFHT_DONE,
  output logic          oOVF
);

  localparam int unsigned EW = A_BIT + 4*D_BIT;
  localparam logic [A_BIT-1:0] LAST_BEAT = {A_BIT{1'b1}};

  wr_state_e               state_q;
  logic [A_BIT-1:0]        beat_cnt_q;
  logic [A_BIT-1:0]        beat_cnt_d;
  logic                    last_stage_q;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    full;
  logic                    empty;
  logic [EW-1:0]           push_word;
  logic [EW-1:0]           head;
  logic [A_BIT-1:0]        head_addr;
  logic signed [D_BIT-1:0] head_y0;
  logic signed [D_BIT-1:0] head_y1;
  logic signed [D_BIT-1:0] head_y2;
  logic signed [D_BIT-1:0] head_y3;

  // Write-side word transform applied at pop.
  function automatic logic signed [D_BIT-1:0] wr_scale(input logic signed [D_BIT-1:0] y);
`ifdef FHT_WR_SCALE_EN
    return D_BIT'(((D_BIT+1)'(y) + $signed((D_BIT+1)'(1))) >>> 1);
`else
    return y;
`endif
  endfunction

  assign beat_cnt_d = beat_cnt_q + A_BIT'(1);
  assign pop        = !empty && bus.iWR_GRANT;
  assign push       = (state_q == ST_RUN) && bus.iVALID && (!full || pop);
  assign drop       = bus.iVALID && ((state_q != ST_RUN) || (full && !pop));
  assign push_word  = {beat_cnt_q, bus.iY_3, bus.iY_2, bus.iY_1, bus.iY_0};

  assign head_addr  = head[EW-1 -: A_BIT];
  assign head_y3    = $signed(head[3*D_BIT +: D_BIT]);
  assign head_y2    = $signed(head[2*D_BIT +: D_BIT]);
  assign head_y1    = $signed(head[1*D_BIT +: D_BIT]);
  assign head_y0    = $signed(head[0 +: D_BIT]);

  fht_wr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (push_word),
    .rdata_c_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Stage FSM, beat counter, overflow flag and registered bank write port.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      last_stage_q <= 1'b0;
      oBUSY        <= 1'b0;
      oSTAGE_DONE  <= 1'b0;
      oFHT_DONE    <= 1'b0;
      oOVF         <= 1'b0;
      bus.oWE      <= 1'b0;
      bus.oADDR    <= '0;
      bus.oD_0     <= '0;
      bus.oD_1     <= '0;
      bus.oD_2     <= '0;
      bus.oD_3     <= '0;
    end else begin
      oSTAGE_DONE <= 1'b0;
      oFHT_DONE   <= 1'b0;
      bus.oWE     <= pop;
      if (pop) begin
        bus.oADDR <= head_addr;
        bus.oD_0  <= wr_scale(head_y0);
        bus.oD_1  <= wr_scale(head_y1);
        bus.oD_2  <= wr_scale(head_y2);
        bus.oD_3  <= wr_scale(head_y3);
      end
      if (drop) oOVF <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            state_q      <= ST_RUN;
            beat_cnt_q   <= '0;
            last_stage_q <= iLAST_STAGE;
            oBUSY        <= 1'b1;
          end
        end
        ST_RUN: begin
          // Dropped beats still advance the counter to keep addresses aligned.
          if (bus.iVALID) begin
            beat_cnt_q <= beat_cnt_d;
            if (beat_cnt_q == LAST_BEAT) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (empty) begin
            state_q     <= ST_DONE;
            oSTAGE_DONE <= 1'b1;
            oFHT_DONE   <= last_stage_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fht_bank_wr.sv
// Bench for fht_bank_wr: directed scenarios plus random stages, compared each
// cycle against a queue-based reference of the write-back behaviour.
module tb_fht_bank_wr;

  localparam int unsigned D_BIT = 17;
  localparam int unsigned A_BIT = 3;
  localparam int unsigned DEPTH = 4;
  localparam int          NB    = 8;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic iCLK;
  logic iRESET;
  logic iSTART;
  logic iLAST_STAGE;
  logic oBUSY;
  logic oSTAGE_DONE;
  logic oFHT_DONE;
  logic oOVF;

  fht_bank_wr_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_bank_wr #(
    .D_BIT      (D_BIT),
    .A_BIT      (A_BIT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .iSTART      (iSTART),
    .iLAST_STAGE (iLAST_STAGE),
    .bus         (bus),
    .oBUSY       (oBUSY),
    .oSTAGE_DONE (oSTAGE_DONE),
    .oFHT_DONE   (oFHT_DONE),
    .oOVF        (oOVF)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: a plain queue of pending {address, words}.
  typedef struct {
    int a;
    int d0;
    int d1;
    int d2;
    int d3;
  } beat_t;

  beat_t q[$];
  int    m_phase;
  int    m_cnt;
  bit    m_last;
  bit    m_we;
  int    m_addr;
  int    m_d[4];
  bit    m_busy;
  bit    m_sd;
  bit    m_fd;
  bit    m_ovf;

  logic signed [D_BIT-1:0] yd[4];

  function automatic int scale_ref(input int v);
`ifdef FHT_WR_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_last  = 0;
    m_we    = 0;
    m_addr  = 0;
    for (int k = 0; k < 4; k++) m_d[k] = 0;
    m_busy  = 0;
    m_sd    = 0;
    m_fd    = 0;
    m_ovf   = 0;
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_step(input bit start, input bit last, input bit valid, input bit grant);
    int    sz;
    bit    pop;
    bit    full;
    beat_t h;
    beat_t nb;
    sz   = q.size();
    pop  = (sz > 0) && grant;
    full = (sz == DEPTH);
    m_sd = 0;
    m_fd = 0;
    m_we = pop;
    if (pop) begin
      h      = q.pop_front();
      m_addr = h.a;
      m_d[0] = scale_ref(h.d0);
      m_d[1] = scale_ref(h.d1);
      m_d[2] = scale_ref(h.d2);
      m_d[3] = scale_ref(h.d3);
    end
    case (m_phase)
      P_IDLE: begin
        if (valid) m_ovf = 1;
        if (start) begin
          m_phase = P_RUN;
          m_cnt   = 0;
          m_last  = last;
        end
      end
      P_RUN: begin
        if (valid) begin
          if (!full || pop) begin
            nb.a  = m_cnt;
            nb.d0 = int'(yd[0]);
            nb.d1 = int'(yd[1]);
            nb.d2 = int'(yd[2]);
            nb.d3 = int'(yd[3]);
            q.push_back(nb);
          end else begin
            m_ovf = 1;
          end
          if (m_cnt == NB - 1) m_phase = P_DRAIN;
          m_cnt = (m_cnt + 1) % NB;
        end
      end
      P_DRAIN: begin
        if (valid) m_ovf = 1;
        if (sz == 0) begin
          m_phase = P_DONE;
          m_sd    = 1;
          m_fd    = m_last;
        end
      end
      default: begin
        if (valid) m_ovf = 1;
        m_phase = P_IDLE;
      end
    endcase
    m_busy = (m_phase != P_IDLE);
  endtask

  task automatic check_all();
    chk("oWE",         longint'(bus.oWE),      longint'(m_we));
    chk("oADDR",       longint'(bus.oADDR),    longint'(m_addr));
    chk("oD_0",        longint'(bus.oD_0),     longint'(m_d[0]));
    chk("oD_1",        longint'(bus.oD_1),     longint'(m_d[1]));
    chk("oD_2",        longint'(bus.oD_2),     longint'(m_d[2]));
    chk("oD_3",        longint'(bus.oD_3),     longint'(m_d[3]));
    chk("oBUSY",       longint'(oBUSY),        longint'(m_busy));
    chk("oSTAGE_DONE", longint'(oSTAGE_DONE),  longint'(m_sd));
    chk("oFHT_DONE",   longint'(oFHT_DONE),    longint'(m_fd));
    chk("oOVF",        longint'(oOVF),         longint'(m_ovf));
  endtask

  // One clock: inputs applied at the falling edge, outputs checked at the next one.
  task automatic cycle(input bit start, input bit last, input bit valid, input bit grant);
    iSTART        = start;
    iLAST_STAGE   = last;
    bus.iVALID    = valid;
    bus.iWR_GRANT = grant;
    bus.iY_0      = yd[0];
    bus.iY_1      = yd[1];
    bus.iY_2      = yd[2];
    bus.iY_3      = yd[3];
    model_step(start, last, valid, grant);
    @(negedge iCLK);
    check_all();
  endtask

  task automatic set_y_pattern(input int b);
    for (int k = 0; k < 4; k++) yd[k] = D_BIT'(10*b + k);
  endtask

  task automatic set_y_rand();
    for (int k = 0; k < 4; k++) yd[k] = D_BIT'($urandom);
  endtask

  task automatic do_reset();
    iRESET        = 1'b0;
    iSTART        = 1'b0;
    iLAST_STAGE   = 1'b0;
    bus.iVALID    = 1'b0;
    bus.iWR_GRANT = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge iCLK);
    check_all();
    iRESET = 1'b1;
  endtask

  task automatic drain_to_idle(input bit rand_grant);
    int guard = 0;
    while (m_phase != P_IDLE && guard < 200) begin
      cycle(1'b0, 1'b0, 1'b0, rand_grant ? bit'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    chk("drain_bound", longint'(m_phase), longint'(P_IDLE));
  endtask

  // Directed stage: 8 pattern beats, grant low for the first n_hold beat cycles.
  task automatic pattern_stage(input bit last, input int n_hold, input int stop_after);
    cycle(1'b1, last, 1'b0, 1'b1);
    for (int b = 0; b < NB && b < stop_after; b++) begin
      set_y_pattern(b);
      cycle(1'b0, 1'b0, 1'b1, (b >= n_hold));
    end
  endtask

  initial begin
    longint obs6[$];
    int     exp6[3];
    for (int k = 0; k < 4; k++) yd[k] = '0;
    model_reset();
    @(negedge iCLK);
    do_reset();

    // Constant grant: one write per beat, addresses 0..7.
    pattern_stage(1'b0, 0, NB);
    drain_to_idle(1'b0);

    // Grant withheld for four beats: FIFO fills, then push+pop while full.
    pattern_stage(1'b0, 4, NB);
    drain_to_idle(1'b0);

    // Grant withheld for five beats: beat 4 dropped, overflow sticks.
    pattern_stage(1'b0, 5, NB);
    drain_to_idle(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Last stage flag, plus a second start during RUN that must be ignored.
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < NB; b++) begin
      set_y_pattern(b);
      cycle((b == 2), 1'b0, 1'b1, 1'b1);
    end
    drain_to_idle(1'b0);

    // Reset mid-stage with three beats queued, then a clean stage.
    pattern_stage(1'b0, 8, 3);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pattern_stage(1'b0, 0, NB);
    drain_to_idle(1'b0);

    // Random stages with random valid/grant, stray starts and stray beats.
    for (int s = 0; s < 12; s++) begin
      int guard = 0;
      set_y_rand();
      cycle(1'b1, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 1)));
      while (m_phase == P_RUN && guard < 200) begin
        set_y_rand();
        cycle(($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        guard++;
        if (s == 6 && guard == 4) do_reset();
      end
      drain_to_idle(1'b1);
      if (s == 8) begin
        set_y_rand();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
      end
    end

`ifdef FHT_WR_SCALE_EN
    // Scaling corner values on bank 0.
    exp6[0] = 32768;
    exp6[1] = -1;
    exp6[2] = 3;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < NB; b++) begin
      set_y_rand();
      if (b == 0) yd[0] = D_BIT'(65535);
      if (b == 1) yd[0] = D_BIT'(-3);
      if (b == 2) yd[0] = D_BIT'(5);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      if (bus.oWE && obs6.size() < 3) obs6.push_back(longint'(bus.oD_0));
    end
    chk("scale_count", longint'(obs6.size()), 3);
    for (int i = 0; i < 3 && i < obs6.size(); i++) chk("scale_d0", obs6[i], longint'(exp6[i]));
    drain_to_idle(1'b0);
`else
    exp6[0] = 0;
    exp6[1] = 0;
    exp6[2] = 0;
    obs6.delete();
    if (obs6.size() != 0) chk("unused", longint'(exp6[0]), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
